sr_cmd_gen: RTL
===============

Name: sr_cmd_gen

Overview:
- Front-end command stage that drives the s/r inputs of the team's SR flip-flop.
- Converts two raw asynchronous push-button inputs (set, clear) into clean, mutually exclusive, single-cycle s/r pulses.
- Synchronises and debounces both inputs, arbitrates simultaneous presses and enforces a hold-off after each command.
- Its outputs can never present the forbidden s=1,r=1 combination to the downstream flop.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive clocks a synchronised input must differ from its stable level before the stable level updates (1 to 2^CNT_W-1).
- HOLDOFF_CYCLES, 3, idle clocks enforced after each issued pulse; 0 disables hold-off (0 to 2^CNT_W-1).
- CNT_W, 8, width of the debounce and hold-off counters.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset; asynchronous and active-low.
- set_btn  input  1  raw asynchronous set request, active-high.
- clr_btn  input  1  raw asynchronous clear request, active-high.
- s_out  output  1  one-cycle set pulse to the SR flop s input.
- r_out  output  1  one-cycle reset pulse to the SR flop r input.
- conflict  output  1  one-cycle flag: set and clear presses were detected in the same cycle.
- busy  output  1  high while a pulse or hold-off is in progress.

Behaviour:
- Reset (rst=0, asynchronous):
  - s_out, r_out, conflict and busy are 0.
  - Synchroniser flops, stable levels and counters are 0.
  - FSM is in IDLE.
  - Outputs go to 0 immediately, including in the middle of a pulse or hold-off.
- Synchroniser: each button passes through a 2-flop synchroniser.
- Debounce, per input:
  - The counter increments on each clock where the synchronised value differs from the stable level.
  - The counter clears on any clock where they agree.
  - When the count reaches DEBOUNCE_CYCLES, the stable level takes the synchronised value and the counter clears.
- Press events:
  - A 0->1 change of a stable level is a one-cycle press event.
  - A 1->0 change (release) produces no event.
- FSM states: IDLE, S_PULSE, R_PULSE, HOLD.
  - IDLE, set event only -> S_PULSE.
  - IDLE, clear event only -> R_PULSE.
  - IDLE, both events in the same cycle -> conflict=1 for one cycle, remain IDLE, no pulse issued.
  - S_PULSE / R_PULSE: last exactly one cycle. Next state is HOLD if HOLDOFF_CYCLES>0, else IDLE.
  - HOLD: lasts exactly HOLDOFF_CYCLES cycles, then IDLE.
- Events arriving while in S_PULSE, R_PULSE or HOLD are discarded, not queued.
- Outputs are registered:
  - s_out=1 exactly in the cycle the FSM is in S_PULSE; r_out=1 exactly in R_PULSE.
  - busy=1 whenever the state is not IDLE.
- Latency: with a raw input held steady high, s_out/r_out asserts on the (DEBOUNCE_CYCLES+4)th rising edge after the first edge that samples it high. For DEBOUNCE_CYCLES=4 that is the 8th edge.
- Glitches: a glitch shorter than DEBOUNCE_CYCLES synchronised clocks produces no event.
- Invariant: s_out and r_out are never 1 in the same cycle, under any stimulus.
- Reset release with a button held: stable level is 0 and the synchronised value is 1, so one press event occurs after the normal debounce.
- Counters saturate and never wrap; parameter range checks are the integrator's responsibility.

Optional Feature:
- Macro: SR_CMD_TOGGLE_EN.
- When defined, the block adds:
  - Input port tog_btn (1 bit, raw asynchronous), with its own synchroniser and debounce identical to the other buttons.
  - Internal shadow bit q_shadow, reset 0. It is set on each S_PULSE and cleared on each R_PULSE.
- A tog_btn press event in IDLE goes to S_PULSE if q_shadow=0, or R_PULSE if q_shadow=1.
- Any two or more simultaneous press events among set, clear and toggle assert conflict and issue no pulse.
- When not defined: tog_btn and q_shadow do not exist, and behaviour is exactly as above.

Test Plan:
- DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=3. Hold set_btn=1 from edge 0 -> s_out=1 only on edge 8. busy=1 on edges 8..11, then 0. r_out stays 0.
- Pulse clr_btn high for 3 clocks, then low -> no r_out, no busy, debounce counter returns to 0.
- set_btn and clr_btn rise on the same clock and are held -> conflict=1 for exactly one cycle. s_out=r_out=0 throughout. No further events until both are released and re-pressed.
- Clear press, then set press whose event lands 1 cycle after the r_out pulse (during HOLD) -> r_out pulse only. The set event is discarded and no s_out follows.
- Assert rst=0 during S_PULSE -> s_out drops to 0 immediately. Hold set_btn through reset release -> a fresh s_out occurs 8 edges after release.
- SR_CMD_TOGGLE_EN defined: three tog_btn presses spaced 20 cycles apart -> s_out, r_out, s_out in order, with q_shadow showing 1, 0, 1.

Source files
------------

// File: rtl/sr_cmd_gen.sv
// Button-to-SR command stage: sync, debounce, arbitrate, pulse, hold-off.
// Optional toggle button enabled by defining SR_CMD_TOGGLE_EN.
module sr_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES  = 3,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic set_btn,
  input  logic clr_btn,
`ifdef SR_CMD_TOGGLE_EN
  input  logic tog_btn,
`endif
  output logic s_out,
  output logic r_out,
  output logic conflict,
  output logic busy
);

`ifdef SR_CMD_TOGGLE_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  localparam logic [CNT_W-1:0] DB = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] HO = CNT_W'(HOLDOFF_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    S_PULSE,
    R_PULSE,
    HOLD
  } state_e;

  logic [NB-1:0] btn;
  logic [NB-1:0] sync1_q, sync2_q;
  logic [NB-1:0] stable_q, stable_d;
  logic [NB-1:0] ev_q, ev_d;
  logic [CNT_W-1:0] cnt_q [NB];
  logic [CNT_W-1:0] cnt_d [NB];

  state_e state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic s_q, r_q, conf_q, busy_q;
  logic conf_d;
  logic multi;

`ifdef SR_CMD_TOGGLE_EN
  logic q_shadow_q, q_shadow_d;
  assign btn = {tog_btn, clr_btn, set_btn};
`else
  assign btn = {clr_btn, set_btn};
`endif

  // Stable level only moves after DB consecutive differing samples.
  always_comb begin
    stable_d = stable_q;
    ev_d     = '0;
    cnt_d    = cnt_q;
    for (int i = 0; i < NB; i++) begin
      if (cnt_q[i] == DB) begin
        stable_d[i] = sync2_q[i];
        ev_d[i]     = sync2_q[i] & ~stable_q[i];
        cnt_d[i]    = '0;
      end else if (sync2_q[i] != stable_q[i]) begin
        cnt_d[i] = (cnt_q[i] == '1) ? cnt_q[i]
                 : cnt_q[i] + 1'b1;
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  assign multi = |(ev_q & (ev_q - 1'b1));

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    conf_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (multi) begin
          conf_d = 1'b1;
        end else begin
          unique case (1'b1)
            ev_q[0]: state_d = S_PULSE;
            ev_q[1]: state_d = R_PULSE;
`ifdef SR_CMD_TOGGLE_EN
            ev_q[2]: state_d = q_shadow_q ? R_PULSE
                                          : S_PULSE;
`endif
            default: state_d = IDLE;
          endcase
        end
      end
      S_PULSE, R_PULSE: begin
        hold_d  = '0;
        state_d = (HO != '0) ? HOLD : IDLE;
      end
      HOLD: begin
        if (hold_q >= HO - 1'b1) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SR_CMD_TOGGLE_EN
  always_comb begin
    q_shadow_d = q_shadow_q;
    if (state_d == S_PULSE) q_shadow_d = 1'b1;
    if (state_d == R_PULSE) q_shadow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_shadow_q <= 1'b0;
    else      q_shadow_q <= q_shadow_d;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      ev_q     <= '0;
      cnt_q    <= '{default: '0};
      state_q  <= IDLE;
      hold_q   <= '0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      conf_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      sync1_q  <= btn;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      ev_q     <= ev_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      hold_q   <= hold_d;
      s_q      <= (state_d == S_PULSE);
      r_q      <= (state_d == R_PULSE);
      conf_q   <= conf_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign s_out    = s_q;
  assign r_out    = r_q;
  assign conflict = conf_q;
  assign busy     = busy_q;

endmodule
